vga_shooter_display: RTL and testbench
======================================

// Module: vga_shooter_display
// PURPOSE
// 640x480@60 Hz VGA timing generator plus single-player shooter renderer. Holds a ship, 8 bullets,
// a row of monsters and a remaining-enemy count, and drives per-pixel RGB with aligned sync/blank.
// Sits between the PS/2 key decoder (move/fire/pause levels) and the board VGA DAC. No background ROM.
// PARAMETERS
// MOVE_DIV      1000000  clocks between ship move ticks
// BULLET_DIV    100000   clocks between bullet move ticks
// NUM_MONSTERS  10       monster count (<=15)
// MONSTER_SIZE  32       monster square side, px
// SCORE_X       600      left x of tens digit; SCORE_Y 10 = top y of both digits
// PORTS
// iVGA_CLK    in   1  25.175 MHz pixel clock
// iRST_n      in   1  reset, asynchronous, active-low
// move_left   in   1  level, ship left request
// move_right  in   1  level, ship right request
// fire        in   1  level; rising edge spawns one bullet
// pause       in   1  level; freezes all game state
// oHS/oVS     out  1  hsync/vsync, active-low
// oBLANK_n    out  1  high in visible area
// r_data/g_data/b_data  out  8 each  pixel colour
// BEHAVIOUR
// - Timing: h_cnt 0..799 (640 vis, 16 FP, 96 sync, 48 BP); v_cnt 0..524 (480 vis, 10 FP, 2 sync, 33 BP).
//   pixel_x=h_cnt, pixel_y=v_cnt. Sync low during sync intervals. Outputs registered: 1-clock latency,
//   sync/blank/RGB mutually aligned. RGB = 0 whenever blanked.
// - Reset (async): counters 0, oHS=oVS=1, oBLANK_n=0, RGB=0, ship_x=320, ship_y=450 (fixed),
//   bullets inactive x=y=0, monster j active at x=50+42*j, y=50, remaining=NUM_MONSTERS, divider counters 0.
// - pause=1: dividers, ship, bullets, fire edge detector, collisions all hold; video continues.
// - Ship tick (move_cnt==MOVE_DIV, then cnt<=0): left: x-=5 if x>5; right: x+=5 if x<624; both -> right wins.
// - Fire: on rising edge of fire (registered detector), lowest-index inactive bullet gets x=ship_x+8,
//   y=ship_y, active. All 8 active -> edge ignored.
// - Bullet tick (bullet_cnt==BULLET_DIV): each active bullet: y<5 -> deactivate, else y-=5.
//   Spawn and tick in same clock: spawn wins for that slot.
// - Collision every clock: active bullet i hits active monster j if mx<=bx<mx+32 and my<=by<my+32.
//   At most one kill per clock: lowest j, then lowest i; both deactivated, remaining-=1, saturate at 0.
//   Kill overrides bullet movement for that bullet.
// - Render priority: ship 16x16 green (00,FF,00) > bullet 4x8 yellow (FF,FF,00) > monster red (FF,00,00)
//   > score digit white (FF,FF,FF) > black. Sprites are rectangles from top-left (x,y).
// - Score: remaining as two decimal digits, tens at (SCORE_X,SCORE_Y), units at (SCORE_X+10,SCORE_Y),
//   8x8 font ROM 0-9, row MSB = leftmost px; lit bit draws white. Font digits: standard 8x8 outline glyphs.
// - Arithmetic: x 10-bit, y 9-bit, compares unsigned, no wrap (bounds above prevent it).
// TESTING
// - Reset, run 1 frame -> 420000 clocks/frame, oHS low 96 clk/line, oVS low 2 lines, oBLANK_n high 640x480.
// - Hold move_right 3 ticks -> ship_x 335; hold at x=620 -> 625 then stops; left at x=5 holds at 5.
// - Fire pulse -> bullet0 at (328,450); after 90 bullet ticks y=0, next tick inactive; 9 pulses -> only 8 live.
// - Place ship_x=52, fire -> bullet reaches y<82, monster0 dies, bullet freed, digits read "09".
// - Pixel (320,450) ship green; (50,50) red; digit pixels at (602,10) white for '1'-'0' at reset count 10.
// - pause=1 for 2 tick periods -> ship/bullets unchanged; async reset mid-frame -> all reset values immediately.

Source files
------------

// File: rtl/vga_shooter_display_if.sv
// Control levels from the key decoder and registered video outputs to the DAC.
interface vga_shooter_display_if;
  logic       move_left;
  logic       move_right;
  logic       fire;
  logic       pause;
  logic       oHS;
  logic       oVS;
  logic       oBLANK_n;
  logic [7:0] r_data;
  logic [7:0] g_data;
  logic [7:0] b_data;

  modport master (
    output move_left, move_right, fire, pause,
    input  oHS, oVS, oBLANK_n, r_data, g_data, b_data
  );

  modport slave (
    input  move_left, move_right, fire, pause,
    output oHS, oVS, oBLANK_n, r_data, g_data, b_data
  );
endinterface

// File: rtl/vga_shooter_display.sv
// 640x480@60 raster plus shooter game state (ship, 8 bullets, monster row, two-digit count).
// Sync, blank and RGB leave one register stage after the raster counters; pause freezes only the game.
module vga_shooter_display #(
  parameter int MOVE_DIV     = 1000000,
  parameter int BULLET_DIV   = 100000,
  parameter int NUM_MONSTERS = 10,
  parameter int MONSTER_SIZE = 32,
  parameter int SCORE_X      = 600,
  parameter int SCORE_Y      = 10
) (
  input logic                  iVGA_CLK,
  input logic                  iRST_n,
  vga_shooter_display_if.slave bus
);
  localparam logic [9:0] H_LAST = 10'd799;
  localparam logic [9:0] V_LAST = 10'd524;
  localparam logic [9:0] H_VIS  = 10'd640;
  localparam logic [9:0] V_VIS  = 10'd480;
  localparam logic [9:0] HS_BEG = 10'd656;
  localparam logic [9:0] HS_END = 10'd752;
  localparam logic [9:0] VS_BEG = 10'd490;
  localparam logic [9:0] VS_END = 10'd492;

  localparam int NB = 8;
  localparam int MW = $clog2(MOVE_DIV + 1);
  localparam int BW = $clog2(BULLET_DIV + 1);

  localparam logic [9:0] SHIP_X0 = 10'd320;
  localparam logic [8:0] SHIP_Y  = 9'd450;
  localparam logic [9:0] SHIP_YV = {1'b0, SHIP_Y};
  localparam logic [8:0] MON_Y   = 9'd50;
  localparam logic [9:0] MON_YV  = {1'b0, MON_Y};
  localparam logic [9:0] MSZ     = 10'(MONSTER_SIZE);
  localparam logic [8:0] MSZ9    = 9'(MONSTER_SIZE);
  localparam logic [9:0] SX      = 10'(SCORE_X);
  localparam logic [9:0] SXU     = 10'(SCORE_X + 10);
  localparam logic [9:0] SY      = 10'(SCORE_Y);
  localparam logic [2:0] SX_LO   = 3'(SCORE_X);
  localparam logic [2:0] SXU_LO  = 3'(SCORE_X + 10);
  localparam logic [2:0] SY_LO   = 3'(SCORE_Y);

  function automatic logic [9:0] mon_x(input int j);
    return 10'(50 + 42 * j);
  endfunction

  function automatic logic [7:0] font_row(input logic [3:0] d, input logic [2:0] r);
    logic [63:0] g;
    case (d)
      4'd0:    g = 64'h3C666E7666663C00;
      4'd1:    g = 64'h3878181818187E00;
      4'd2:    g = 64'h3C66060C30607E00;
      4'd3:    g = 64'h3C66061C06663C00;
      4'd4:    g = 64'h0C1C3C6C7E0C0C00;
      4'd5:    g = 64'h7E607C0606663C00;
      4'd6:    g = 64'h3C607C6666663C00;
      4'd7:    g = 64'h7E060C1830303000;
      4'd8:    g = 64'h3C66663C66663C00;
      4'd9:    g = 64'h3C66663E060C3800;
      default: g = '0;
    endcase
    return g[{3'd7 - r, 3'b000} +: 8];
  endfunction

  logic [9:0]              h_cnt;
  logic [9:0]              v_cnt;
  logic [MW-1:0]           move_cnt;
  logic [BW-1:0]           bullet_cnt;
  logic [9:0]              ship_x;
  logic                    fire_q;
  logic [NB-1:0]           bul_act;
  logic [9:0]              bul_x [NB];
  logic [8:0]              bul_y [NB];
  logic [NUM_MONSTERS-1:0] mon_act;
  logic [3:0]              remaining;

  logic       move_tick;
  logic       bullet_tick;
  logic       fire_edge;
  logic       spawn_free;
  logic [2:0] spawn_i;
  logic       kill;
  logic [2:0] kill_b;
  logic [3:0] kill_m;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign move_tick   = (move_cnt == MW'(MOVE_DIV));
  assign bullet_tick = (bullet_cnt == BW'(BULLET_DIV));
  assign fire_edge   = bus.fire & ~fire_q;

  always_comb begin
    spawn_free = 1'b0;
    spawn_i    = 3'd0;
    for (int i = 0; i < NB; i++) begin
      if (!spawn_free && !bul_act[i]) begin
        spawn_free = 1'b1;
        spawn_i    = 3'(i);
      end
    end
  end

  // Outer loop over monsters so the first hit found is lowest monster, then lowest bullet.
  always_comb begin
    kill   = 1'b0;
    kill_b = 3'd0;
    kill_m = 4'd0;
    for (int j = 0; j < NUM_MONSTERS; j++) begin
      for (int i = 0; i < NB; i++) begin
        if (!kill && mon_act[j] && bul_act[i] &&
            bul_x[i] >= mon_x(j) && bul_x[i] < mon_x(j) + MSZ &&
            bul_y[i] >= MON_Y && bul_y[i] < MON_Y + MSZ9) begin
          kill   = 1'b1;
          kill_b = 3'(i);
          kill_m = 4'(j);
        end
      end
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      move_cnt   <= '0;
      bullet_cnt <= '0;
      ship_x     <= SHIP_X0;
      fire_q     <= 1'b0;
      bul_act    <= '0;
      for (int i = 0; i < NB; i++) begin
        bul_x[i] <= '0;
        bul_y[i] <= '0;
      end
      mon_act    <= '1;
      remaining  <= 4'(NUM_MONSTERS);
    end else if (!bus.pause) begin
      fire_q     <= bus.fire;
      move_cnt   <= move_tick ? '0 : move_cnt + 1'b1;
      bullet_cnt <= bullet_tick ? '0 : bullet_cnt + 1'b1;

      if (move_tick) begin
        if (bus.move_right) begin
          if (ship_x < 10'd624) ship_x <= ship_x + 10'd5;
        end else if (bus.move_left) begin
          if (ship_x > 10'd5) ship_x <= ship_x - 10'd5;
        end
      end

      for (int i = 0; i < NB; i++) begin
        if (kill && kill_b == 3'(i)) begin
          bul_act[i] <= 1'b0;
        end else if (fire_edge && spawn_free && spawn_i == 3'(i)) begin
          bul_act[i] <= 1'b1;
          bul_x[i]   <= ship_x + 10'd8;
          bul_y[i]   <= SHIP_Y;
        end else if (bullet_tick && bul_act[i]) begin
          if (bul_y[i] < 9'd5) bul_act[i] <= 1'b0;
          else                 bul_y[i]   <= bul_y[i] - 9'd5;
        end
      end

      for (int j = 0; j < NUM_MONSTERS; j++) begin
        if (kill && kill_m == 4'(j)) mon_act[j] <= 1'b0;
      end
      if (kill && remaining != 4'd0) remaining <= remaining - 4'd1;
    end
  end

  logic        visible;
  logic        hs_n;
  logic        vs_n;
  logic        ship_hit;
  logic        bul_hit;
  logic        mon_hit;
  logic        digit_lit;
  logic [3:0]  tens;
  logic [3:0]  units;
  logic [2:0]  srow;
  logic [2:0]  col_t;
  logic [2:0]  col_u;
  logic [7:0]  bits;
  logic [23:0] color;

  always_comb begin
    visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hs_n    = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    vs_n    = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));

    ship_hit = (h_cnt >= ship_x) && (h_cnt < ship_x + 10'd16) &&
               (v_cnt >= SHIP_YV) && (v_cnt < SHIP_YV + 10'd16);

    bul_hit = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (bul_act[i] && h_cnt >= bul_x[i] && h_cnt < bul_x[i] + 10'd4 &&
          v_cnt >= {1'b0, bul_y[i]} && v_cnt < {1'b0, bul_y[i]} + 10'd8)
        bul_hit = 1'b1;
    end

    mon_hit = 1'b0;
    for (int j = 0; j < NUM_MONSTERS; j++) begin
      if (mon_act[j] && h_cnt >= mon_x(j) && h_cnt < mon_x(j) + MSZ &&
          v_cnt >= MON_YV && v_cnt < MON_YV + MSZ)
        mon_hit = 1'b1;
    end

    // remaining never exceeds 15, so the tens digit is 0 or 1.
    tens  = (remaining >= 4'd10) ? 4'd1 : 4'd0;
    units = (remaining >= 4'd10) ? remaining - 4'd10 : remaining;
    srow  = v_cnt[2:0] - SY_LO;
    col_t = h_cnt[2:0] - SX_LO;
    col_u = h_cnt[2:0] - SXU_LO;

    bits      = 8'd0;
    digit_lit = 1'b0;
    if (v_cnt >= SY && v_cnt < SY + 10'd8) begin
      if (h_cnt >= SX && h_cnt < SX + 10'd8) begin
        bits      = font_row(tens, srow);
        digit_lit = bits[3'd7 - col_t];
      end else if (h_cnt >= SXU && h_cnt < SXU + 10'd8) begin
        bits      = font_row(units, srow);
        digit_lit = bits[3'd7 - col_u];
      end
    end

    color = 24'h000000;
    if (ship_hit)       color = 24'h00FF00;
    else if (bul_hit)   color = 24'hFFFF00;
    else if (mon_hit)   color = 24'hFF0000;
    else if (digit_lit) color = 24'hFFFFFF;
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      bus.oHS      <= 1'b1;
      bus.oVS      <= 1'b1;
      bus.oBLANK_n <= 1'b0;
      bus.r_data   <= 8'd0;
      bus.g_data   <= 8'd0;
      bus.b_data   <= 8'd0;
    end else begin
      bus.oHS      <= hs_n;
      bus.oVS      <= vs_n;
      bus.oBLANK_n <= visible;
      bus.r_data   <= visible ? color[23:16] : 8'd0;
      bus.g_data   <= visible ? color[15:8]  : 8'd0;
      bus.b_data   <= visible ? color[7:0]   : 8'd0;
    end
  end
endmodule

// File: tb/tb_vga_shooter_display.sv
// Directed bench: line timing, ship/bullet/kill behaviour, pause, raster pixel colours, async reset.
module tb_vga_shooter_display;
  localparam int MD = 3;
  localparam int BD = 7;
  localparam int PM = MD + 1;
  localparam int PB = BD + 1;

  logic iVGA_CLK = 1'b0;
  logic iRST_n   = 1'b0;
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;

  vga_shooter_display_if bus();

  vga_shooter_display #(.MOVE_DIV(MD), .BULLET_DIV(BD)) dut (
    .iVGA_CLK(iVGA_CLK),
    .iRST_n  (iRST_n),
    .bus     (bus)
  );

  always #20 iVGA_CLK = ~iVGA_CLK;

  // Posedges since reset release: after edge k the outputs show raster pixel k-1.
  always @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge iVGA_CLK);
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic [23:0] exp);
    int target;
    int guard;
    target = y * 800 + x + 1;
    guard  = 0;
    while (cyc < target && guard < 100000) begin
      @(negedge iVGA_CLK);
      guard++;
    end
    if (cyc != target) begin
      checks++;
      errors++;
      $error("FAIL %s raster position observed=%0d expected=%0d", tag, cyc, target);
    end else begin
      check(tag, {8'd0, bus.r_data, bus.g_data, bus.b_data}, {8'd0, exp});
    end
  endtask

  initial begin
    int hs_low, bl_hi, vs_low, first_hs, rgb_bad;
    bus.move_left  = 1'b0;
    bus.move_right = 1'b0;
    bus.fire       = 1'b0;
    bus.pause      = 1'b0;
    step(3);

    check("rst_hs", bus.oHS, 1);
    check("rst_vs", bus.oVS, 1);
    check("rst_blank", bus.oBLANK_n, 0);
    check("rst_rgb", {bus.r_data, bus.g_data, bus.b_data}, 0);
    check("rst_ship_x", dut.ship_x, 320);
    check("rst_remaining", dut.remaining, 10);
    check("rst_bul_act", dut.bul_act, 0);
    check("rst_mon_act", dut.mon_act, 10'h3FF);

    iRST_n = 1'b1;
    hs_low = 0; bl_hi = 0; vs_low = 0; first_hs = 0; rgb_bad = 0;
    for (int k = 1; k <= 800; k++) begin
      step(1);
      if (!bus.oHS) begin
        hs_low++;
        if (first_hs == 0) first_hs = k;
      end
      if (bus.oBLANK_n) bl_hi++;
      if (!bus.oVS) vs_low++;
      if (!bus.oBLANK_n && {bus.r_data, bus.g_data, bus.b_data} != 24'd0) rgb_bad++;
    end
    check("line_hs_low", hs_low, 96);
    check("line_hs_start", first_hs, 657);
    check("line_blank_hi", bl_hi, 640);
    check("line_vs_low", vs_low, 0);
    check("line_rgb_blanked", rgb_bad, 0);

    // 53 left ticks: 320 -> 55, so the bullet spawns at x=63 inside monster 0.
    bus.move_left = 1'b1;
    step(53 * PM);
    bus.move_left = 1'b0;
    check("left53_ship_x", dut.ship_x, 55);

    bus.fire = 1'b1;
    step(1);
    bus.fire = 1'b0;
    check("spawn_act", dut.bul_act, 8'h01);
    check("spawn_x", dut.bul_x[0], 63);
    check("spawn_y", dut.bul_y[0], 450);

    step(73 * PB);
    check("fly73_y", dut.bul_y[0], 85);
    check("fly73_remaining", dut.remaining, 10);
    step(2 * PB);
    check("kill_bul_act", dut.bul_act, 0);
    check("kill_mon_act", dut.mon_act, 10'h3FE);
    check("kill_remaining", dut.remaining, 9);

    pix("digit_tens0_c0", 600, 10, 24'h000000);
    pix("digit_tens0_c2", 602, 10, 24'hFFFFFF);
    pix("digit_units9_r3c6", 616, 13, 24'hFFFFFF);
    pix("digit_units9_r3c7", 617, 13, 24'h000000);
    pix("digit_units9_r6c2", 612, 16, 24'hFFFFFF);
    pix("monster0_dead", 50, 50, 24'h000000);
    pix("monster1_left", 92, 50, 24'hFF0000);
    pix("monster1_right", 123, 50, 24'hFF0000);
    pix("monster_gap", 124, 50, 24'h000000);

    iRST_n = 1'b0;
    step(2);
    iRST_n = 1'b1;

    bus.move_right = 1'b1;
    step(3 * PM);
    bus.move_right = 1'b0;
    check("right3_ship_x", dut.ship_x, 335);

    bus.fire = 1'b1;
    step(1);
    bus.fire = 1'b0;
    check("spawn2_x", dut.bul_x[0], 343);
    step(86 * PB);
    check("fly86_y", dut.bul_y[0], 20);

    bus.pause      = 1'b1;
    bus.move_right = 1'b1;
    bus.fire       = 1'b1;
    step(PB);
    bus.fire = 1'b0;
    step(PB);
    bus.move_right = 1'b0;
    check("pause_ship_x", dut.ship_x, 335);
    check("pause_bul_y", dut.bul_y[0], 20);
    check("pause_bul_act", dut.bul_act, 8'h01);

    pix("bullet_tl", 343, 20, 24'hFFFF00);
    pix("bullet_tr", 346, 20, 24'hFFFF00);
    pix("bullet_right_edge", 347, 20, 24'h000000);
    pix("bullet_br", 346, 27, 24'hFFFF00);
    pix("bullet_below", 343, 28, 24'h000000);

    bus.pause = 1'b0;
    step(4 * PB);
    check("fly90_y", dut.bul_y[0], 0);
    check("fly90_act", dut.bul_act[0], 1);
    step(PB);
    check("fly91_act", dut.bul_act[0], 0);

    for (int k = 0; k < 9; k++) begin
      bus.fire = 1'b1;
      step(1);
      bus.fire = 1'b0;
      step(1);
    end
    check("nine_pulses_act", dut.bul_act, 8'hFF);
    check("nine_pulses_x7", dut.bul_x[7], 343);

    bus.move_right = 1'b1;
    step(57 * PM);
    check("right_to_620", dut.ship_x, 620);
    step(PM);
    check("right_to_625", dut.ship_x, 625);
    step(3 * PM);
    check("right_stop_625", dut.ship_x, 625);
    bus.move_left = 1'b1;
    step(PM);
    check("both_right_wins_625", dut.ship_x, 625);
    bus.move_right = 1'b0;
    step(124 * PM);
    check("left_to_5", dut.ship_x, 5);
    step(2 * PM);
    check("left_stop_5", dut.ship_x, 5);
    bus.move_right = 1'b1;
    step(PM);
    check("both_right_wins_10", dut.ship_x, 10);
    bus.move_right = 1'b0;
    bus.move_left  = 1'b0;
    check("no_kill_remaining", dut.remaining, 10);

    #5;
    iRST_n = 1'b0;
    #1;
    check("arst_ship_x", dut.ship_x, 320);
    check("arst_bul_act", dut.bul_act, 0);
    check("arst_h_cnt", dut.h_cnt, 0);
    check("arst_hs", bus.oHS, 1);
    check("arst_vs", bus.oVS, 1);
    check("arst_blank", bus.oBLANK_n, 0);
    check("arst_rgb", {bus.r_data, bus.g_data, bus.b_data}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
